// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types: RF address/data/byte-enable widths and the
// writeback buffer entry layout.
package riscv_v_pkg;

   localparam int RISCV_V_RF_ADDR_W  = 5;
   localparam int RISCV_V_DATA_W     = 128;
   localparam int RISCV_V_RF_WR_EN_W = RISCV_V_DATA_W / 8;

   typedef logic [RISCV_V_RF_ADDR_W-1:0]  riscv_v_rf_addr_t;
   typedef logic [RISCV_V_DATA_W-1:0]     riscv_v_data_t;
   typedef logic [RISCV_V_RF_WR_EN_W-1:0] riscv_v_rf_wr_en_t;

   typedef struct packed {
      riscv_v_rf_addr_t  addr;
      riscv_v_data_t     data;
      riscv_v_rf_wr_en_t wr_en;
   } riscv_v_wb_entry_t;

endpackage

// File: rtl/riscv_v_rf_wb_buffer.sv
// In-order writeback FIFO in front of the vector RF write port. Retires one
// entry per cycle when the port is free and flags RAW hazards for the two RF
// read addresses against every pending or incoming write.
module riscv_v_rf_wb_buffer
   import riscv_v_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              res_valid,
   output logic              res_ready,
   input  riscv_v_rf_addr_t  res_addr,
   input  riscv_v_data_t     res_data,
   input  riscv_v_rf_wr_en_t res_wr_en,
   input  logic              flush,
   input  logic              rf_port_busy,
   input  riscv_v_rf_addr_t  rd_addr_A,
   input  riscv_v_rf_addr_t  rd_addr_B,
   output logic              hazard_A,
   output logic              hazard_B,
   output riscv_v_rf_addr_t  wr_addr,
   output riscv_v_data_t     data_in,
   output riscv_v_rf_wr_en_t wr_en,
   output logic              empty,
   output logic [PTR_W:0]    count
);

   localparam int CNT_W = PTR_W + 1;

   riscv_v_wb_entry_t mem [DEPTH];
   riscv_v_wb_entry_t head;
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [DEPTH-1:0]  live;
   logic              push_hs, store, pop, incoming;

   assign head      = mem[rd_ptr_q];
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign res_ready = (count_q != CNT_W'(DEPTH));
   assign push_hs   = res_valid & res_ready;
   // Zero-enable results finish the handshake but never occupy a slot.
   assign incoming  = push_hs & (res_wr_en != '0);
   assign store     = incoming & ~flush;
   assign pop       = ~empty & ~rf_port_busy & ~flush;

   assign wr_addr = empty ? '0 : head.addr;
   assign data_in = empty ? '0 : head.data;
   assign wr_en   = pop ? head.wr_en : '0;

   // Mark slots holding a pending entry: distance from head below count.
   always_comb begin
      live = '0;
      for (int i = 0; i < DEPTH; i++) begin
         live[i] = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
      end
   end

   // Hazard: any live entry or the accepted incoming result targets the read address.
   always_comb begin
      hazard_A = incoming & (res_addr == rd_addr_A);
      hazard_B = incoming & (res_addr == rd_addr_B);
      for (int i = 0; i < DEPTH; i++) begin
         if (live[i] && (mem[i].addr == rd_addr_A)) hazard_A = 1'b1;
         if (live[i] && (mem[i].addr == rd_addr_B)) hazard_B = 1'b1;
      end
      if (flush) begin
         hazard_A = 1'b0;
         hazard_B = 1'b0;
      end
   end

   // Pointer and occupancy state; flush wins over any push or pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (store) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({store, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage, intentionally not reset.
   always_ff @(posedge clk) begin
      if (store) mem[wr_ptr_q] <= '{addr: res_addr, data: res_data, wr_en: res_wr_en};
   end

endmodule
